// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: debounced mode key, four display modes, registered 7-seg outputs.
// Optional HEX_DP_BLINK_EN: the HEX_0 decimal point blinks with the scroll tick.
module hex_display_scheduler #(
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] SW_A,
  input  logic [3:0] SW_B,
  input  logic       KEY_MODE,
  output logic [7:0] HEX_0,
  output logic [7:0] HEX_1,
  output logic [7:0] HEX_2,
  output logic [7:0] HEX_3,
  output logic [1:0] MODE
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    RAW    = 2'b00,
    SUM    = 2'b01,
    SCROLL = 2'b10,
    BLANK  = 2'b11
  } state_t;

  typedef struct packed {
    logic       off;
    logic [3:0] val;
  } digit_t;

  localparam digit_t DARK = '{off: 1'b1, val: 4'h0};

  function automatic logic [6:0] seg(input digit_t d);
    logic [6:0] s;
    s = 7'h7F;
    if (!d.off) begin
      case (d.val)
        4'h0: s = 7'h40;
        4'h1: s = 7'h79;
        4'h2: s = 7'h24;
        4'h3: s = 7'h30;
        4'h4: s = 7'h19;
        4'h5: s = 7'h12;
        4'h6: s = 7'h02;
        4'h7: s = 7'h78;
        4'h8: s = 7'h00;
        4'h9: s = 7'h10;
        4'hA: s = 7'h08;
        4'hB: s = 7'h03;
        4'hC: s = 7'h46;
        4'hD: s = 7'h21;
        4'hE: s = 7'h06;
        4'hF: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  logic          key_s1;
  logic          key_s2;
  logic          key_deb;
  logic          key_deb_d;
  logic [DW-1:0] deb_cnt;
  logic          adv;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_deb   <= 1'b1;
      key_deb_d <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      key_s1    <= KEY_MODE;
      key_s2    <= key_s1;
      key_deb_d <= key_deb;
      if (key_s2 == key_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        key_deb <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Only a debounced press advances; release is ignored.
  assign adv = key_deb_d & ~key_deb;

  logic [TW-1:0] tick_cnt;
  logic          tick_wrap;
  logic          tick;

  assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
  assign tick      = tick_wrap & ~adv;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= '0;
    end else if (adv || tick_wrap) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  state_t       state;
  digit_t [3:0] scr;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= RAW;
      scr   <= {4{DARK}};
    end else if (adv) begin
      state <= state_t'(state + 2'd1);
      if (state == SUM) begin
        scr[3] <= {1'b0, SW_A};
        scr[2] <= {1'b0, SW_B};
        scr[1] <= DARK;
        scr[0] <= DARK;
      end
    end else if (tick && state == SCROLL) begin
      scr[3] <= scr[2];
      scr[2] <= scr[1];
      scr[1] <= scr[0];
      scr[0] <= scr[3];
    end
  end

  logic         dp0;

`ifdef HEX_DP_BLINK_EN
  logic hb;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hb <= 1'b0;
    end else if (state == BLANK) begin
      hb <= 1'b0;
    end else if (tick) begin
      hb <= ~hb;
    end
  end

  assign dp0 = ~hb;
`else
  assign dp0 = 1'b1;
`endif

  logic [4:0]   sum;
  digit_t [3:0] disp;

  always_comb begin
    sum  = {1'b0, SW_A} + {1'b0, SW_B};
    disp = {4{DARK}};
    unique case (state)
      RAW: begin
        disp[0] = {1'b0, SW_A};
        disp[1] = {1'b0, SW_B};
      end
      SUM: begin
        disp[0] = {1'b0, sum[3:0]};
        disp[1] = {1'b0, 3'b000, sum[4]};
        disp[2] = {1'b0, SW_B};
        disp[3] = {1'b0, SW_A};
      end
      SCROLL: disp = scr;
      BLANK:  disp = {4{DARK}};
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      HEX_0 <= 8'hFF;
      HEX_1 <= 8'hFF;
      HEX_2 <= 8'hFF;
      HEX_3 <= 8'hFF;
      MODE  <= 2'b00;
    end else begin
      HEX_0 <= {dp0 | (state == BLANK), seg(disp[0])};
      HEX_1 <= {1'b1, seg(disp[1])};
      HEX_2 <= {1'b1, seg(disp[2])};
      HEX_3 <= {1'b1, seg(disp[3])};
      MODE  <= state;
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: directed + random steps against a digit-level reference model.
// Build with or without HEX_DP_BLINK_EN; the model follows the same macro.
module tb_hex_display_scheduler;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_a;
  logic [3:0] sw_b;
  logic       key;
  logic [7:0] hex0, hex1, hex2, hex3;
  logic [1:0] mode;

  always #5 clk = ~clk;

  hex_display_scheduler #(
    .TICK_DIV(TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .SW_A(sw_a),
    .SW_B(sw_b),
    .KEY_MODE(key),
    .HEX_0(hex0),
    .HEX_1(hex1),
    .HEX_2(hex2),
    .HEX_3(hex3),
    .MODE(mode)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  bit         m_s1, m_s2, m_deb, m_deb_d, m_hb;
  int         m_run, m_cnt, m_mode, m_rot;
  int         m_pat [4];
  logic [7:0] e_hex [4];
  logic [1:0] e_mode;

  function automatic logic [7:0] enc(input int v);
    return (v < 0) ? 8'hFF : seg_tab[v];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_deb = 1; m_deb_d = 1; m_hb = 0;
    m_run = 0; m_cnt = 0; m_mode = 0; m_rot = 0;
    for (int n = 0; n < 4; n++) begin
      m_pat[n] = -1;
      e_hex[n] = 8'hFF;
    end
    e_mode = 2'b00;
  endtask

  // One clock edge: outputs from the pre-edge state, then state update.
  task automatic model_edge();
    int dig [4];
    int s;
    bit adv, tick, nd;
    adv  = m_deb_d && !m_deb;
    tick = !adv && (m_cnt == TD - 1);
    for (int n = 0; n < 4; n++) dig[n] = -1;
    case (m_mode)
      0: begin
        dig[0] = int'(sw_a);
        dig[1] = int'(sw_b);
      end
      1: begin
        s = int'(sw_a) + int'(sw_b);
        dig[0] = s % 16;
        dig[1] = s / 16;
        dig[2] = int'(sw_b);
        dig[3] = int'(sw_a);
      end
      2: for (int n = 0; n < 4; n++) dig[n] = m_pat[(n - m_rot + 4) % 4];
      default: ;
    endcase
    for (int n = 0; n < 4; n++) e_hex[n] = enc(dig[n]);
`ifdef HEX_DP_BLINK_EN
    if (m_mode != 3) e_hex[0][7] = !m_hb;
`endif
    e_mode = 2'(m_mode);
    if (m_mode == 3) m_hb = 0;
    else if (tick) m_hb = !m_hb;
    if (adv) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 2) begin
        m_pat[3] = int'(sw_a);
        m_pat[2] = int'(sw_b);
        m_pat[1] = -1;
        m_pat[0] = -1;
        m_rot = 0;
      end
    end else if (tick && m_mode == 2) begin
      m_rot = (m_rot + 1) % 4;
    end
    m_cnt = adv ? 0 : (m_cnt + 1) % TD;
    nd = m_deb;
    if (m_s2 != m_deb) m_run++;
    else m_run = 0;
    if (m_run == DB) begin
      nd = m_s2;
      m_run = 0;
    end
    m_deb_d = m_deb;
    m_deb = nd;
    m_s2 = m_s1;
    m_s1 = key;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".h0"}, hex0, e_hex[0]);
    chk({tag, ".h1"}, hex1, e_hex[1]);
    chk({tag, ".h2"}, hex2, e_hex[2]);
    chk({tag, ".h3"}, hex3, e_hex[3]);
    chk({tag, ".mode"}, {6'b0, mode}, {6'b0, e_mode});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Step until the adv of a press started now sees tick counter value pre.
  task automatic align(input int pre, input string tag);
    for (int i = 0; i < TD && (m_cnt + DB + 2) % TD != pre; i++) step(tag);
  endtask

  task automatic press(input string tag);
    key = 1'b0;
    repeat (8) step(tag);
    key = 1'b1;
    repeat (8) step(tag);
  endtask

  task automatic chk_scroll_start(input string tag);
    chk({tag, ".h3"}, hex3, 8'hF9);
    chk({tag, ".h2"}, hex2, 8'hA4);
    chk({tag, ".h1"}, hex1, 8'hFF);
    chk({tag, ".h0"}, hex0 | 8'h80, 8'hFF);
  endtask

  initial begin
    int first;
    rst_n = 1'b0;
    key   = 1'b1;
    sw_a  = 4'h0;
    sw_b  = 4'h0;
    model_reset();
    #12;
    chk("rst.h0", hex0, 8'hFF);
    chk("rst.h3", hex3, 8'hFF);
    chk("rst.mode", {6'b0, mode}, 8'h00);
    rst_n = 1'b1;

    sw_a = 4'h3;
    sw_b = 4'hA;
    step("raw");
    chk("raw.h0", hex0 | 8'h80, 8'hB0);
    chk("raw.h1", hex1, 8'h88);
    chk("raw.h2", hex2, 8'hFF);
    chk("raw.h3", hex3, 8'hFF);
    repeat (16) begin
      sw_a = 4'($urandom);
      sw_b = 4'($urandom);
      step("raw_rnd");
    end

    key = 1'b0;
    repeat (2) step("short");
    key = 1'b1;
    repeat (10) step("short_rel");
    chk("short.mode", {6'b0, mode}, 8'h00);

    first = 0;
    key = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step("long");
      if (first == 0 && mode == 2'b01) first = i;
    end
    key = 1'b1;
    repeat (10) step("long_rel");
    chk("long.latency", 8'(first), 8'(DB + 4));
    chk("long.mode", {6'b0, mode}, 8'h01);

    sw_a = 4'hF;
    sw_b = 4'hF;
    step("sum_ff");
    chk("sum_ff.h0", hex0 | 8'h80, 8'h86);
    chk("sum_ff.h1", hex1, 8'hF9);
    chk("sum_ff.h2", hex2, 8'h8E);
    chk("sum_ff.h3", hex3, 8'h8E);
    sw_a = 4'h0;
    sw_b = 4'h0;
    step("sum_00");
    chk("sum_00.h0", hex0 | 8'h80, 8'hC0);
    chk("sum_00.h1", hex1, 8'hC0);
    repeat (16) begin
      sw_a = 4'($urandom);
      sw_b = 4'($urandom);
      step("sum_rnd");
    end

    // Enter SCROLL mid-count so a missing counter clear shows up early.
    sw_a = 4'h1;
    sw_b = 4'h2;
    align(1, "align_scr");
    key = 1'b0;
    first = 0;
    for (int i = 1; i <= 12 && first == 0; i++) begin
      step("enter_scr");
      if (mode == 2'b10) first = i;
    end
    chk("scr.latency", 8'(first), 8'(DB + 4));
    chk_scroll_start("scr.start");
    repeat (3) step("scr_wait");
    chk_scroll_start("scr.norot");
    step("scr_tick1");
    chk("scr1.h3", hex3, 8'hA4);
    chk("scr1.h2", hex2, 8'hFF);
    chk("scr1.h1", hex1, 8'hFF);
    chk("scr1.h0", hex0 | 8'h80, 8'hF9);
    key = 1'b1;
    repeat (12) begin
      sw_a = 4'($urandom);
      step("scr_sw");
    end
    chk_scroll_start("scr.wrap");

    press("to_blank");
    chk("blank.h0", hex0, 8'hFF);
    chk("blank.h1", hex1, 8'hFF);
    chk("blank.mode", {6'b0, mode}, 8'h03);
    repeat (5) step("blank");

    // Leave BLANK with adv landing on a tick.
    sw_a = 4'h5;
    sw_b = 4'hC;
    align(TD - 1, "align_raw");
    press("to_raw");
    chk("raw2.mode", {6'b0, mode}, 8'h00);
    chk("raw2.h0", hex0 | 8'h80, 8'h92);
    chk("raw2.h1", hex1, 8'hC6);
    repeat (8) begin
      sw_a = 4'($urandom);
      sw_b = 4'($urandom);
      step("raw2_rnd");
    end

    press("to_sum2");
    repeat (3) step("sum2");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.h0", hex0, 8'hFF);
    chk("arst.h1", hex1, 8'hFF);
    chk("arst.h2", hex2, 8'hFF);
    chk("arst.h3", hex3, 8'hFF);
    chk("arst.mode", {6'b0, mode}, 8'h00);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (6) begin
      sw_a = 4'($urandom);
      sw_b = 4'($urandom);
      step("post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
